// File: rtl/if_branch_stash_pkg.sv
// Shared types for the IF -> EX in-flight branch stash.
// Entry layout, default geometry and redirect arithmetic used by IF and EX.
// Pure declarations; no state.
package if_branch_stash_pkg;

  localparam int          STASH_DEPTH       = 4;
  localparam int          STASH_PTR_W       = 2;
  localparam logic [31:0] STASH_INSTR_BYTES = 32'd4;

  // One in-flight predicted branch as recorded by IF
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_take;
    logic [31:0] pred_target;
  } stash_entry_t;

  localparam int STASH_ENTRY_W = $bits(stash_entry_t);

  // Correct next PC once the real direction is known (32-bit wrap on fall-through)
  function automatic logic [31:0] resolve_next_pc(input logic        take,
                                                  input logic [31:0] target,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] step);
    return take ? target : (pc + step);
  endfunction

endpackage

// File: rtl/branch_stash_fifo.sv
// Circular entry store for the branch stash: write at tail, read head combinationally.
// Latency: push visible at head the cycle after it is written; pop takes effect on the edge.
// Backpressure: push dropped when full unless a pop frees a slot the same cycle; flush wins.
module branch_stash_fifo
  import if_branch_stash_pkg::*;
#(
  parameter int DEPTH = STASH_DEPTH,
  parameter int PTR_W = STASH_PTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [STASH_ENTRY_W-1:0] i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [STASH_ENTRY_W-1:0] o_head_dat,
  output logic [PTR_W:0]           o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LP_CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [STASH_ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [PTR_W:0]           r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == LP_CNT_MAX);
  assign w_empty   = (r_count == '0);
  // A pop on an empty store is meaningless; the caller reports it separately
  assign w_do_pop  = i_pop && !w_empty;
  // A slot freed by a same-cycle pop may be reused immediately; a flush drops the push
  assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

  // Entry storage needs no reset: only slots between head and tail are ever read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards every queued entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + LP_PTR_ONE;
      end
      if (w_do_pop) begin
        r_head <= r_head + LP_PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + LP_CNT_ONE;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - LP_CNT_ONE;
      end
    end
  end

  assign o_head_dat = r_mem[r_head];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule

// File: rtl/if_branch_stash.sv
// In-flight branch stash between IF prediction and EX in-order resolution.
// Latency: resolve -> BHT feedback / mispredict strobe exactly 1 cycle, registered.
// Backpressure: full tells IF to stall branch fetch; a mispredict flushes and drops same-cycle push.
module if_branch_stash
  import if_branch_stash_pkg::*;
#(
  parameter int          DEPTH       = STASH_DEPTH,
  parameter int          PTR_W       = STASH_PTR_W,
  parameter logic [31:0] INSTR_BYTES = STASH_INSTR_BYTES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [31:0]    push_pc,
  input  logic           push_pred_take,
  input  logic [31:0]    push_pred_target,
  output logic           full,
  input  logic           resolve,
  input  logic           resolve_take,
  input  logic [31:0]    resolve_target,
  output logic           pc_jmp_feedback,
  output logic           pc_jmp_take,
  output logic [31:0]    pc_stash_base,
  output logic           mispredict,
  output logic [31:0]    redirect_pc,
  output logic [PTR_W:0] count,
  output logic           underflow_err
);

  stash_entry_t             w_push_ent;
  stash_entry_t             w_head;
  logic [STASH_ENTRY_W-1:0] w_push_dat;
  logic [STASH_ENTRY_W-1:0] w_head_dat;
  logic                     w_empty;
  logic                     w_full;
  logic [PTR_W:0]           w_count;
  logic                     w_resolve_ok;
  logic                     w_dir_wrong;
  logic                     w_tgt_wrong;
  logic                     w_mispredict;

  logic        r_pc_jmp_feedback;
  logic        r_pc_jmp_take;
  logic [31:0] r_pc_stash_base;
  logic        r_mispredict;
  logic [31:0] r_redirect_pc;
  logic        r_underflow_err;

  assign w_push_ent = '{pc: push_pc, pred_take: push_pred_take, pred_target: push_pred_target};
  assign w_push_dat = w_push_ent;
  assign w_head     = stash_entry_t'(w_head_dat);

  // Only a resolve against a real entry counts; resolve on empty is an EX protocol error
  assign w_resolve_ok = resolve && !w_empty;
  assign w_dir_wrong  = (w_head.pred_take != resolve_take);
  // Target only matters when both IF and EX agree the branch was taken
  assign w_tgt_wrong  = resolve_take && w_head.pred_take &&
                        (w_head.pred_target != resolve_target);
  assign w_mispredict = w_resolve_ok && (w_dir_wrong || w_tgt_wrong);

  branch_stash_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_resolve_ok),
    .i_flush    (w_mispredict),
    .o_head_dat (w_head_dat),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Strobes pulse for one cycle per resolve; data fields hold until the next resolve
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_jmp_feedback <= 1'b0;
      r_pc_jmp_take     <= 1'b0;
      r_pc_stash_base   <= '0;
      r_mispredict      <= 1'b0;
      r_redirect_pc     <= '0;
    end else begin
      r_pc_jmp_feedback <= w_resolve_ok;
      r_mispredict      <= w_mispredict;
      if (w_resolve_ok) begin
        r_pc_jmp_take   <= resolve_take;
        r_pc_stash_base <= w_head.pc;
      end
      if (w_mispredict) begin
        r_redirect_pc <= resolve_next_pc(resolve_take, resolve_target,
                                         w_head.pc, INSTR_BYTES);
      end
    end
  end

  // Sticky record that EX resolved a branch nobody had pushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underflow_err <= 1'b0;
    end else if (resolve && w_empty) begin
      r_underflow_err <= 1'b1;
    end
  end

  assign full            = w_full;
  assign count           = w_count;
  assign pc_jmp_feedback = r_pc_jmp_feedback;
  assign pc_jmp_take     = r_pc_jmp_take;
  assign pc_stash_base   = r_pc_stash_base;
  assign mispredict      = r_mispredict;
  assign redirect_pc     = r_redirect_pc;
  assign underflow_err   = r_underflow_err;

endmodule
